// File: rtl/sync_mod_counter.sv
// sync_mod_counter: fully synchronous modulo up/down counter with parallel
// load, synchronous clear, wrap or saturate at the range ends, and a
// combinational terminal count for chaining stages into a wider counter.
module sync_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int RST_VAL  = 0,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  // Range limits carried one bit wider so MODULUS = 2**WIDTH stays exact.
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   TOP_X = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

  logic [WIDTH:0]   count_x;
  logic [WIDTH:0]   din_x;
  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] count_nxt;

  assign count_x = {1'b0, count};
  assign din_x   = {1'b0, din};
  assign at_top  = (count_x == TOP_X);
  assign at_bot  = (count_x == '0);

  // Terminal count is only meaningful when this edge would actually step.
  assign tc = en & ~clr & ~load & (up ? at_top : at_bot);

  // Next count: clear beats clamped load beats a single step; otherwise hold.
  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = (din_x >= MOD_X) ? TOP : din;
    end else if (en) begin
      if (up) begin
        if (at_top) count_nxt = SATURATE ? count : '0;
        else        count_nxt = WIDTH'(count_x + ONE_X);
      end else begin
        if (at_bot) count_nxt = SATURATE ? '0 : TOP;
        else        count_nxt = WIDTH'(count_x - ONE_X);
      end
    end
  end

  // Count register; reset forces RST_VAL without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= RST_W;
    else     count <= count_nxt;
  end

  // Wrap pulse is tc delayed one cycle; tc already masks clr/load edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap <= 1'b0;
    else     wrap <= tc;
  end

endmodule

// File: tb/tb_sync_mod_counter.sv
// tb_sync_mod_counter: self-checking bench for sync_mod_counter using a
// scoreboard queue of expected post-edge count/wrap values.
module tb_sync_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int cnt;
    bit wr;
  } exp_t;
  exp_t sbq[$];

  // a: WIDTH=4 MODULUS=16 RST_VAL=5, wrapping
  logic       a_rst, a_clr, a_load, a_en, a_up, a_tc, a_wrap;
  logic [3:0] a_din, a_count;
  // b: MODULUS=10, wrapping
  logic       g_rst;
  logic       b_clr, b_load, b_en, b_up, b_tc, b_wrap;
  logic [3:0] b_din, b_count;
  // c: MODULUS=10, saturating
  logic       c_clr, c_load, c_en, c_up, c_tc, c_wrap;
  logic [3:0] c_din, c_count;
  // cascade: lo and hi, WIDTH=4 MODULUS=16
  logic       x_clr, x_load, x_en, x_up;
  logic [3:0] lo_din, hi_din, lo_count, hi_count;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

  sync_mod_counter #(.WIDTH(4), .MODULUS(16), .RST_VAL(5), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst(a_rst), .clr(a_clr), .load(a_load), .din(a_din), .en(a_en),
    .up(a_up), .count(a_count), .tc(a_tc), .wrap(a_wrap));

  sync_mod_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(0), .SATURATE(1'b0)) u_b (
    .clk(clk), .rst(g_rst), .clr(b_clr), .load(b_load), .din(b_din), .en(b_en),
    .up(b_up), .count(b_count), .tc(b_tc), .wrap(b_wrap));

  sync_mod_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(0), .SATURATE(1'b1)) u_c (
    .clk(clk), .rst(g_rst), .clr(c_clr), .load(c_load), .din(c_din), .en(c_en),
    .up(c_up), .count(c_count), .tc(c_tc), .wrap(c_wrap));

  sync_mod_counter #(.WIDTH(4), .MODULUS(16), .RST_VAL(0), .SATURATE(1'b0)) u_lo (
    .clk(clk), .rst(g_rst), .clr(x_clr), .load(x_load), .din(lo_din), .en(x_en),
    .up(x_up), .count(lo_count), .tc(lo_tc), .wrap(lo_wrap));

  sync_mod_counter #(.WIDTH(4), .MODULUS(16), .RST_VAL(0), .SATURATE(1'b0)) u_hi (
    .clk(clk), .rst(g_rst), .clr(x_clr), .load(x_load), .din(hi_din), .en(lo_tc),
    .up(x_up), .count(hi_count), .tc(hi_tc), .wrap(hi_wrap));

  task automatic test_reset();
    exp_t e;
    vectors++;
    if (a_count !== 4'd5 || b_count !== 4'd0 || c_count !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_value: a=%0d b=%0d c=%0d, expected a=5 b=0 c=0",
               a_count, b_count, c_count);
    end
    // Drive u_a to a wrap so wrap is high when reset lands mid-cycle.
    a_din = 4'd15; a_load = 1'b1; a_en = 1'b1; a_up = 1'b1;
    @(posedge clk); #1;
    a_load = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (a_count !== 4'd0 || a_wrap !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_wrap: count=%0d wrap=%b, expected count=0 wrap=1",
               a_count, a_wrap);
    end
    #2 a_rst = 1'b1;
    #1;
    vectors++;
    if (a_count !== 4'd5 || a_wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: count=%0d wrap=%b, expected count=5 wrap=0",
               a_count, a_wrap);
    end
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if (a_count !== 4'd5 || a_wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold: count=%0d wrap=%b, expected count=5 wrap=0",
                 a_count, a_wrap);
      end
    end
    @(negedge clk);
    a_rst = 1'b0;
    sbq.push_back('{6, 1'b0});
    @(posedge clk); #1;
    e = sbq.pop_front();
    vectors++;
    if (a_count !== 4'(e.cnt) || a_wrap !== e.wr) begin
      miscompares++;
      $display("FAIL reset_release: count=%0d wrap=%b, expected count=%0d wrap=%b",
               a_count, a_wrap, e.cnt, e.wr);
    end
    a_en = 1'b0;
  endtask

  task automatic test_mod10_wrap();
    exp_t e;
    int cur;
    b_en = 1'b1; b_up = 1'b1;
    #1;
    for (int i = 0; i < 11; i++) begin
      cur = i % 10;
      vectors++;
      if (b_tc !== (cur == 9)) begin
        miscompares++;
        $display("FAIL mod10_tc: count=%0d tc=%b, expected tc=%b", b_count, b_tc, cur == 9);
      end
      sbq.push_back('{(cur + 1) % 10, cur == 9});
      @(posedge clk); #1;
      e = sbq.pop_front();
      vectors++;
      if (b_count !== 4'(e.cnt) || b_wrap !== e.wr) begin
        miscompares++;
        $display("FAIL mod10_step: count=%0d wrap=%b, expected count=%0d wrap=%b",
                 b_count, b_wrap, e.cnt, e.wr);
      end
    end
    b_en = 1'b0;
  endtask

  task automatic test_down_saturate();
    exp_t e;
    int exp_cnt[5] = '{1, 0, 0, 0, 0};
    bit exp_tc[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    c_din = 4'd2; c_load = 1'b1;
    sbq.push_back('{2, 1'b0});
    @(posedge clk); #1;
    e = sbq.pop_front();
    vectors++;
    if (c_count !== 4'(e.cnt) || c_wrap !== e.wr) begin
      miscompares++;
      $display("FAIL sat_load: count=%0d wrap=%b, expected count=%0d wrap=%b",
               c_count, c_wrap, e.cnt, e.wr);
    end
    c_load = 1'b0; c_en = 1'b1; c_up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) c_en = 1'b0;
      #1;
      vectors++;
      if (c_tc !== exp_tc[i]) begin
        miscompares++;
        $display("FAIL sat_tc: step=%0d count=%0d tc=%b, expected tc=%b",
                 i, c_count, c_tc, exp_tc[i]);
      end
      sbq.push_back('{exp_cnt[i], exp_tc[i]});
      @(posedge clk); #1;
      e = sbq.pop_front();
      vectors++;
      if (c_count !== 4'(e.cnt) || c_wrap !== e.wr) begin
        miscompares++;
        $display("FAIL sat_step: step=%0d count=%0d wrap=%b, expected count=%0d wrap=%b",
                 i, c_count, c_wrap, e.cnt, e.wr);
      end
    end
  endtask

  task automatic test_priority();
    exp_t e;
    // Each row: clr, load, din, en, up applied to a counter preloaded to pre.
    int pre[3]     = '{7, 7, 9};
    bit p_clr[3]   = '{1'b1, 1'b0, 1'b0};
    int p_din[3]   = '{3, 3, 4};
    int p_exp[3]   = '{0, 3, 4};
    for (int i = 0; i < 3; i++) begin
      b_clr = 1'b0; b_load = 1'b1; b_en = 1'b0; b_din = 4'(pre[i]);
      @(posedge clk); #1;
      b_clr = p_clr[i]; b_load = 1'b1; b_din = 4'(p_din[i]); b_en = 1'b1; b_up = 1'b1;
      #1;
      vectors++;
      if (b_tc !== 1'b0) begin
        miscompares++;
        $display("FAIL prio_tc: row=%0d tc=%b, expected tc=0", i, b_tc);
      end
      sbq.push_back('{p_exp[i], 1'b0});
      @(posedge clk); #1;
      e = sbq.pop_front();
      vectors++;
      if (b_count !== 4'(e.cnt) || b_wrap !== e.wr) begin
        miscompares++;
        $display("FAIL prio_step: row=%0d count=%0d wrap=%b, expected count=%0d wrap=%b",
                 i, b_count, b_wrap, e.cnt, e.wr);
      end
    end
    b_clr = 1'b0; b_load = 1'b0; b_en = 1'b0;
  endtask

  task automatic test_clamp();
    exp_t e;
    int dins[4] = '{14, 10, 9, 15};
    b_en = 1'b0; b_load = 1'b1;
    foreach (dins[i]) begin
      b_din = 4'(dins[i]);
      sbq.push_back('{(dins[i] > 9) ? 9 : dins[i], 1'b0});
      @(posedge clk); #1;
      e = sbq.pop_front();
      vectors++;
      if (b_count !== 4'(e.cnt) || b_wrap !== e.wr) begin
        miscompares++;
        $display("FAIL clamp_load: din=%0d count=%0d, expected count=%0d",
                 dins[i], b_count, e.cnt);
      end
    end
    b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
    sbq.push_back('{0, 1'b1});
    @(posedge clk); #1;
    e = sbq.pop_front();
    vectors++;
    if (b_count !== 4'(e.cnt) || b_wrap !== e.wr) begin
      miscompares++;
      $display("FAIL clamp_wrap: count=%0d wrap=%b, expected count=%0d wrap=%b",
               b_count, b_wrap, e.cnt, e.wr);
    end
    b_en = 1'b0;
  endtask

  task automatic test_direction_change();
    exp_t e;
    bit dir[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    int want[4] = '{4, 3, 2, 3};
    b_load = 1'b1; b_din = 4'd3; b_en = 1'b0;
    @(posedge clk); #1;
    b_load = 1'b0; b_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_up = dir[i];
      sbq.push_back('{want[i], 1'b0});
      @(posedge clk); #1;
      e = sbq.pop_front();
      vectors++;
      if (b_count !== 4'(e.cnt) || b_wrap !== e.wr) begin
        miscompares++;
        $display("FAIL dir_change: step=%0d count=%0d, expected count=%0d", i, b_count, e.cnt);
      end
    end
    b_en = 1'b0;
  endtask

  task automatic test_cascade();
    exp_t e;
    int starts[3] = '{8'h0F, 8'h00, 8'hFF};
    bit dirs[3]   = '{1'b1, 1'b0, 1'b1};
    int nexts[3]  = '{8'h10, 8'hFF, 8'h00};
    bit hiwr[3]   = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      x_load = 1'b1; x_en = 1'b0;
      lo_din = 4'(starts[i] % 16); hi_din = 4'(starts[i] / 16);
      @(posedge clk); #1;
      x_load = 1'b0; x_en = 1'b1; x_up = dirs[i];
      #1;
      vectors++;
      if (lo_tc !== 1'b1 || hi_tc !== hiwr[i]) begin
        miscompares++;
        $display("FAIL cascade_tc: row=%0d lo_tc=%b hi_tc=%b, expected lo_tc=1 hi_tc=%b",
                 i, lo_tc, hi_tc, hiwr[i]);
      end
      sbq.push_back('{nexts[i], hiwr[i]});
      @(posedge clk); #1;
      e = sbq.pop_front();
      vectors++;
      if ({hi_count, lo_count} !== 8'(e.cnt) || hi_wrap !== e.wr || lo_wrap !== 1'b1) begin
        miscompares++;
        $display("FAIL cascade_step: row=%0d value=%02h hi_wrap=%b lo_wrap=%b, expected value=%02h hi_wrap=%b lo_wrap=1",
                 i, {hi_count, lo_count}, hi_wrap, lo_wrap, e.cnt, e.wr);
      end
      x_en = 1'b0;
    end
  endtask

  initial begin
    a_rst = 1'b1; g_rst = 1'b1;
    a_clr = 1'b0; a_load = 1'b0; a_en = 1'b0; a_up = 1'b1; a_din = '0;
    b_clr = 1'b0; b_load = 1'b0; b_en = 1'b0; b_up = 1'b1; b_din = '0;
    c_clr = 1'b0; c_load = 1'b0; c_en = 1'b0; c_up = 1'b1; c_din = '0;
    x_clr = 1'b0; x_load = 1'b0; x_en = 1'b0; x_up = 1'b1; lo_din = '0; hi_din = '0;
    @(negedge clk);
    a_rst = 1'b0; g_rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_mod10_wrap();
    test_down_saturate();
    test_priority();
    test_clamp();
    test_direction_change();
    test_cascade();
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
